// File: rtl/regfile.sv
// regfile: 2**RADDR_WIDTH x RDATA_WIDTH register file, x0 hardwired zero.
// Ports: clk_i, rst_i (async low), write port (reg_we/waddr/wdata), two read ports (reN/raddrN/rdataN).
module regfile #(
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic                   re1_i,
  input  logic [RADDR_WIDTH-1:0] raddr1_i,
  output logic [RDATA_WIDTH-1:0] rdata1_o,
  input  logic                   re2_i,
  input  logic [RADDR_WIDTH-1:0] raddr2_i,
  output logic [RDATA_WIDTH-1:0] rdata2_o
);

  localparam int NREG = 2 ** RADDR_WIDTH;

  logic [RDATA_WIDTH-1:0] regs_q [NREG];
  logic                   wr_en;

  // Writes to x0 are dropped here, so the stored x0 never leaves zero.
  assign wr_en = reg_we_i && (reg_waddr_i != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[reg_waddr_i] <= reg_wdata_i;
    end
  end

  // Priority: reset, disabled port, x0, same-cycle writeback bypass, storage.
  function automatic logic [RDATA_WIDTH-1:0] rd_mux(
    input logic                   re,
    input logic [RADDR_WIDTH-1:0] ra
  );
    logic [RDATA_WIDTH-1:0] d;
    d = '0;
    if (!rst_i) begin
      d = '0;
    end else if (!re) begin
      d = '0;
    end else if (ra == '0) begin
      d = '0;
    end else if (wr_en && (reg_waddr_i == ra)) begin
      d = reg_wdata_i;
    end else begin
      d = regs_q[ra];
    end
    return d;
  endfunction

  always_comb begin
    rdata1_o = '0;
    rdata1_o = rd_mux(re1_i, raddr1_i);
  end

  always_comb begin
    rdata2_o = '0;
    rdata2_o = rd_mux(re2_i, raddr2_i);
  end

endmodule
